// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single-port node memory (1-cycle synchronous read) among NUM_REQ masters.
//   It uses round-robin arbitration with hold-until-release, so one master's multi-cycle
//   read/modify/write sequence is never interleaved with another master's accesses.
//   Index 0 is winnerPolicy.
//
//   Optional feature: define ARB_TIMEOUT_EN to enable the grant watchdog (MAX_HOLD cycles).
//
// Ports
//   clock, nrst      rising-edge clock, asynchronous active-low reset
//   req              per-master request, held high for the whole access sequence
//   req_address      per-master address, master k at [k*ADDR_WIDTH +: ADDR_WIDTH]
//   req_wr_en        per-master write enable
//   req_data_out     per-master write data, packed like req_address
//   gnt              one-hot grant (registered)
//   rd_data          memory read data (passthrough of mem_data_in)
//   rd_valid         per-master pulse: rd_data holds the word for that master's previous read
//   mem_address, mem_wr_en, mem_data_out   to memory (muxed from the granted master)
//   mem_data_in      from memory
//   busy             high while a grant is held (registered)
//   timeout          sticky watchdog flag (tied 0 without ARB_TIMEOUT_EN)
module mem_port_arbiter #(
    parameter int unsigned NUM_REQ    = 3,
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned MAX_HOLD   = 64
) (
    input  logic                            clock,
    input  logic                            nrst,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_address,
    input  logic [NUM_REQ-1:0]              req_wr_en,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data_out,
    output logic [NUM_REQ-1:0]              gnt,
    output logic [DATA_WIDTH-1:0]           rd_data,
    output logic [NUM_REQ-1:0]              rd_valid,
    output logic [ADDR_WIDTH-1:0]           mem_address,
    output logic                            mem_wr_en,
    output logic [DATA_WIDTH-1:0]           mem_data_out,
    input  logic [DATA_WIDTH-1:0]           mem_data_in,
    output logic                            busy,
    output logic                            timeout
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = 16;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_HOLD < 2) begin : g_param_check
        $error("mem_port_arbiter: unsupported parameter value");
    end

    logic [0:0]         state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [PTR_W-1:0]   last_q, last_d;
    logic               busy_q, busy_d;
    logic [NUM_REQ-1:0] rd_valid_q, rd_valid_d;
    logic [NUM_REQ-1:0] eligible;
    logic               win_found;
    logic [PTR_W-1:0]   win_idx;
    logic [PTR_W-1:0]   cand;

`ifdef ARB_TIMEOUT_EN
    logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [NUM_REQ-1:0] skip_q, skip_d;
    logic               timeout_q, timeout_d;

    // A master revoked by the watchdog sits out exactly one arbitration round
    assign eligible = req & ~skip_q;
    assign timeout  = timeout_q;
`else
    assign eligible = req;
    assign timeout  = 1'b0;
`endif

    // Round-robin scan starting just after the last winner
    always_comb begin : arb_scan
        win_found = 1'b0;
        win_idx   = last_q;
        cand      = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = PTR_W'((32'(last_q) + i) % NUM_REQ);
            if (!win_found && eligible[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Next-state logic
    always_comb begin : next_state
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_d     = last_q;
        busy_d     = busy_q;
        rd_valid_d = gnt_q & ~req_wr_en;
`ifdef ARB_TIMEOUT_EN
        timeout_d  = timeout_q;
        skip_d     = skip_q;
        hold_cnt_d = hold_cnt_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef ARB_TIMEOUT_EN
                skip_d = '0;
`endif
                if (win_found) begin
                    state_d = HOLD;
                    gnt_d   = NUM_REQ'(1) << win_idx;
                    last_d  = win_idx;
                    busy_d  = 1'b1;
`ifdef ARB_TIMEOUT_EN
                    hold_cnt_d = '0;
`endif
                end
            end
            HOLD: begin
                if (!req[last_q]) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                end
`ifdef ARB_TIMEOUT_EN
                else if (hold_cnt_q == CNT_W'(MAX_HOLD - 1)) begin
                    state_d   = IDLE;
                    gnt_d     = '0;
                    busy_d    = 1'b0;
                    timeout_d = 1'b1;
                    skip_d    = gnt_q;
                end else begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
`endif
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            last_q     <= PTR_W'(NUM_REQ - 1);
            busy_q     <= 1'b0;
            rd_valid_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_q     <= last_d;
            busy_q     <= busy_d;
            rd_valid_q <= rd_valid_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    // Watchdog registers
    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            hold_cnt_q <= '0;
            skip_q     <= '0;
            timeout_q  <= 1'b0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            skip_q     <= skip_d;
            timeout_q  <= timeout_d;
        end
    end
`endif

    // Memory mux driven from the registered grant; no grant means all zeros
    always_comb begin : mem_mux
        mem_address  = '0;
        mem_wr_en    = 1'b0;
        mem_data_out = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (gnt_q[k]) begin
                mem_address  = req_address[k*ADDR_WIDTH +: ADDR_WIDTH];
                mem_wr_en    = req_wr_en[k];
                mem_data_out = req_data_out[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign gnt      = gnt_q;
    assign busy     = busy_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = mem_data_in;

endmodule
